// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit. An internal accumulator can stand in for
// operand B, and the output stage carries registered zero/parity/popcount flags.
module logic_unit_pipe #(
  parameter int WIDTH = 16,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             use_acc,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             parity,
  output logic [CW-1:0]    ones
);

  typedef enum logic [2:0] {
    OP_NOT  = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_XOR  = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_res_q, s1_res_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;
  logic             parity_q, parity_d;
  logic [CW-1:0]    ones_q, ones_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             s2_adv, s1_adv, in_fire;
  logic [WIDTH-1:0] b_x, res;
  logic [CW-1:0]    pop;

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  assign in_fire  = in_valid && s1_adv;

  always_comb begin
    b_x = use_acc ? acc_q : B;
    case (op)
      OP_NOT:  res = ~A;
      OP_AND:  res = A & b_x;
      OP_OR:   res = A | b_x;
      OP_XOR:  res = A ^ b_x;
      OP_NAND: res = ~(A & b_x);
      OP_NOR:  res = ~(A | b_x);
      OP_XNOR: res = ~(A ^ b_x);
      default: res = A;
    endcase
  end

  // Flags are derived from the S1 result so that S2 holds them as plain registers.
  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + CW'(s1_res_q[i]);
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_res_d    = s1_res_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    zero_d      = zero_q;
    parity_d    = parity_q;
    ones_d      = ones_q;
    acc_d       = acc_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_fire) begin
        s1_res_d = res;
      end
    end

    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_d    = s1_res_q;
        zero_d   = (pop == '0);
        parity_d = ^s1_res_q;
        ones_d   = pop;
      end
    end

    // Clear wins over the update; a same-cycle transfer already used the old value.
    if (acc_clr) begin
      acc_d = '0;
    end else if (in_fire) begin
      acc_d = res;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_res_q    <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      zero_q      <= 1'b0;
      parity_q    <= 1'b0;
      ones_q      <= '0;
      acc_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_res_q    <= s1_res_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      zero_q      <= zero_d;
      parity_q    <= parity_d;
      ones_q      <= ones_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign zero      = zero_q;
  assign parity    = parity_q;
  assign ones      = ones_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: directed cases on a 16-bit instance, then random traffic
// on 16-bit and 7-bit instances checked every cycle against an in-order queue model.
module tb_logic_unit_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  logic        iv0 = 0, ir0, ua0 = 0, ac0 = 0, ov0, or0 = 1, z0, p0;
  logic [2:0]  op0 = 0;
  logic [15:0] a0 = 0, b0 = 0, o0;
  logic [4:0]  n0;

  logic        iv1 = 0, ir1, ua1 = 0, ac1 = 0, ov1, or1 = 1, z1, p1;
  logic [2:0]  op1 = 0;
  logic [6:0]  a1 = 0, b1 = 0, o1;
  logic [2:0]  n1;

  logic_unit_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .op(op0), .A(a0), .B(b0),
    .use_acc(ua0), .acc_clr(ac0), .out_valid(ov0), .out_ready(or0), .out(o0),
    .zero(z0), .parity(p0), .ones(n0)
  );

  logic_unit_pipe #(.WIDTH(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .op(op1), .A(a1), .B(b1),
    .use_acc(ua1), .acc_clr(ac1), .out_valid(ov1), .out_ready(or1), .out(o1),
    .zero(z1), .parity(p1), .ones(n1)
  );

  int checks = 0;
  int errs   = 0;

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s (w%0d): got %0h expected %0h", nm, (g == 0) ? 16 : 7, act, exp);
    end
  endtask

  // Reference model: results queued in acceptance order, each tagged with its accept edge.
  logic [15:0] fifo_r [2][4];
  int          fifo_t [2][4];
  int          wp [2];
  int          rp [2];
  logic [15:0] acc_m [2];
  int          cyc = 0;
  bit          started = 0;
  bit          rst_seen = 0;

  function automatic logic [15:0] model_op(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] bx, input int w);
    logic [15:0] m, r;
    m = 16'((32'd1 << w) - 1);
    case (op)
      3'd0: r = ~a;
      3'd1: r = a & bx;
      3'd2: r = a | bx;
      3'd3: r = a ^ bx;
      3'd4: r = ~(a & bx);
      3'd5: r = ~(a | bx);
      3'd6: r = ~(a ^ bx);
      default: r = a;
    endcase
    return r & m;
  endfunction

  task automatic model_edge(input int g, input bit fin, input bit fout, input logic [2:0] op,
                            input logic [15:0] a, input logic [15:0] b, input logic ua,
                            input logic clr, input int w);
    logic [15:0] r;
    if (fout && (wp[g] > rp[g])) rp[g]++;
    if (fin) begin
      r = model_op(op, a, ua ? acc_m[g] : b, w);
      fifo_r[g][wp[g] % 4] = r;
      fifo_t[g][wp[g] % 4] = cyc;
      wp[g]++;
    end
    if (clr) acc_m[g] = '0;
    else if (fin) acc_m[g] = r;
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      started  = 1;
      rst_seen = 1;
      for (int g = 0; g < 2; g++) begin
        wp[g] = 0; rp[g] = 0; acc_m[g] = '0;
      end
    end else if (started) begin
      rst_seen = 0;
      model_edge(0, iv0 && ir0, ov0 && or0, op0, a0, b0, ua0, ac0, 16);
      model_edge(1, iv1 && ir1, ov1 && or1, op1, 16'(a1), 16'(b1), ua1, ac1, 7);
    end
  end

  task automatic check_inst(input int g, input logic ov, input logic ir, input logic ordy,
                            input logic [15:0] o, input logic z, input logic p, input int n);
    int cnt;
    bit ev;
    logic [15:0] e;
    cnt = wp[g] - rp[g];
    if (rst_seen) begin
      chk("rst_out_valid", g, ov, 0);
      chk("rst_out", g, o, 0);
      chk("rst_zero", g, z, 0);
      chk("rst_parity", g, p, 0);
      chk("rst_ones", g, n, 0);
      chk("rst_in_ready", g, ir, 1);
    end else begin
      ev = (cnt > 0) && (fifo_t[g][rp[g] % 4] < cyc);
      chk("out_valid", g, ov, ev);
      if (ev && ov) begin
        e = fifo_r[g][rp[g] % 4];
        chk("out", g, o, e);
        chk("zero", g, z, ($countones(e) == 0));
        chk("parity", g, p, $countones(e) % 2);
        chk("ones", g, n, $countones(e));
      end
      chk("in_ready", g, ir, (cnt < 2) || ordy);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check_inst(0, ov0, ir0, or0, o0, z0, p0, 32'(n0));
      check_inst(1, ov1, ir1, or1, 16'(o1), z1, p1, 32'(n1));
    end
  end

  task automatic send0(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic ua);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    iv0 = 1; op0 = op; a0 = a; b0 = b; ua0 = ua;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      if (ir0) begin ok = 1; break; end
    end
    chk("send_accept", 0, ok, 1);
    #1 iv0 = 0;
  endtask

  task automatic expect0(input string nm, input logic [15:0] eo, input int eones,
                         input logic ep, input logic ez);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ov0) break;
    end
    chk({nm, "_valid"}, 0, ov0, 1);
    chk({nm, "_out"}, 0, o0, eo);
    chk({nm, "_ones"}, 0, n0, eones);
    chk({nm, "_parity"}, 0, p0, ep);
    chk({nm, "_zero"}, 0, z0, ez);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    bit f0, f1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // Single NOT with exact two-cycle latency and one-cycle output pulse
    send0(3'd0, 16'h00FF, 16'h0000, 0);
    @(negedge clk); chk("t1_early", 0, ov0, 0);
    @(negedge clk);
    chk("t1_valid", 0, ov0, 1);
    chk("t1_out", 0, o0, 16'hFF00);
    chk("t1_ones", 0, n0, 8);
    chk("t1_parity", 0, p0, 0);
    chk("t1_zero", 0, z0, 0);
    @(negedge clk); chk("t1_pulse", 0, ov0, 0);

    send0(3'd1, 16'hFFFF, 16'h0000, 0);
    expect0("t2_and", 16'h0000, 0, 0, 1);
    send0(3'd5, 16'h0000, 16'h0000, 0);
    expect0("t2_nor", 16'hFFFF, 16, 0, 0);
    send0(3'd3, 16'h0001, 16'h0000, 0);
    expect0("t2_xor", 16'h0001, 1, 1, 0);

    // Backpressure: two accepted, third stalls, then drain in order without gaps
    @(posedge clk); #1;
    or0 = 0; iv0 = 1; op0 = 3'd7; ua0 = 0; b0 = 0; a0 = 16'h1111;
    @(posedge clk); chk("t3_acc1", 0, ir0, 1); #1 a0 = 16'h2222;
    @(posedge clk); chk("t3_acc2", 0, ir0, 1); #1 a0 = 16'h3333;
    @(posedge clk); chk("t3_full", 0, ir0, 0); #1;
    @(posedge clk); chk("t3_full2", 0, ir0, 0); #1 or0 = 1;
    @(negedge clk); chk("t3_v1", 0, ov0, 1); chk("t3_o1", 0, o0, 16'h1111);
    @(posedge clk); chk("t3_acc3", 0, ir0, 1); #1 iv0 = 0;
    @(negedge clk); chk("t3_v2", 0, ov0, 1); chk("t3_o2", 0, o0, 16'h2222);
    @(negedge clk); chk("t3_v3", 0, ov0, 1); chk("t3_o3", 0, o0, 16'h3333);
    @(negedge clk); chk("t3_done", 0, ov0, 0);

    // Accumulator chaining and clear; B is driven with junk to show it is ignored
    do_reset();
    send0(3'd3, 16'h1234, 16'hFFFF, 1);
    expect0("t4_x1", 16'h1234, 5, 1, 0);
    send0(3'd3, 16'h1234, 16'hFFFF, 1);
    expect0("t4_x2", 16'h0000, 0, 0, 1);
    send0(3'd7, 16'h5555, 16'hFFFF, 0);
    expect0("t4_pass", 16'h5555, 8, 0, 0);
    @(posedge clk); #1 ac0 = 1;
    @(posedge clk); #1 ac0 = 0;
    send0(3'd2, 16'h00F0, 16'hFFFF, 1);
    expect0("t4_or", 16'h00F0, 4, 0, 0);

    // Reset with two transactions in flight
    @(posedge clk); #1 or0 = 0;
    send0(3'd7, 16'hAAAA, 16'h0000, 0);
    send0(3'd7, 16'h5555, 16'h0000, 0);
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("t5_ov", 0, ov0, 0);
    chk("t5_out", 0, o0, 0);
    chk("t5_ir", 0, ir0, 1);
    or0 = 1;
    send0(3'd7, 16'hBEEF, 16'h0000, 0);
    expect0("t5_beef", 16'hBEEF, 13, 1, 0);
    @(negedge clk); chk("t5_alone1", 0, ov0, 0);
    @(negedge clk); chk("t5_alone2", 0, ov0, 0);

    // Random traffic on both widths
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk);
      f0 = iv0 && ir0;
      f1 = iv1 && ir1;
      #1;
      if (f0 || !iv0) begin
        iv0 = ($urandom_range(0, 3) != 0);
        op0 = 3'($urandom_range(0, 7));
        a0  = 16'($urandom);
        b0  = 16'($urandom);
        ua0 = 1'($urandom_range(0, 1));
      end
      if (f1 || !iv1) begin
        iv1 = ($urandom_range(0, 3) != 0);
        op1 = 3'($urandom_range(0, 7));
        a1  = 7'($urandom);
        b1  = 7'($urandom);
        ua1 = 1'($urandom_range(0, 1));
      end
      ac0 = ($urandom_range(0, 15) == 0);
      ac1 = ($urandom_range(0, 15) == 0);
      or0 = ($urandom_range(0, 3) != 0);
      or1 = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    iv0 = 0; iv1 = 0; ac0 = 0; ac1 = 0; or0 = 1; or1 = 1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

endmodule
